// File: rtl/ms_stopwatch_ctrl.sv
// ms_stopwatch_ctrl: stopwatch sequencer for the millisecond counter datapath.
// Divides CLK to a centisecond tick, runs the idle/run/lap/pause FSM from
// single-cycle button pulses, advances the cs/sec/min cascade and presents
// either the live count or a frozen lap capture on registered outputs.
//
// Button pulses are one-cycle strobes with no handshake: a pulse is acted on
// at the rising edge where it is sampled high. At most one pulse acts per
// edge; CLEAR outranks START_STOP, which outranks LAP, and any lower-ranked
// pulse arriving with a higher-ranked one is dropped, even when the winning
// pulse has no effect in the current state.
module ms_stopwatch_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int MAX_MIN  = 59
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START_STOP,
    input  logic       LAP,
    input  logic       CLEAR,
    output logic [6:0] CS,
    output logic [5:0] SEC,
    output logic [5:0] MIN,
    output logic       RUNNING,
    output logic       LAP_HOLD,
    output logic       OVF,
    output logic       TICK
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam int              PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]      MIN_LAST = 6'(MAX_MIN);

    state_t        state_q,  state_d;
    logic [PW-1:0] pre_q,    pre_d;
    logic [6:0]    cs_q,     cs_d;
    logic [5:0]    sec_q,    sec_d;
    logic [5:0]    min_q,    min_d;
    logic [6:0]    lap_cs_q, lap_cs_d;
    logic [5:0]    lap_sec_q, lap_sec_d;
    logic [5:0]    lap_min_q, lap_min_d;
    logic          ovf_q,    ovf_d;

    logic          counting;
    logic          tick_now;
    logic          at_max;
    logic          do_clr;
    logic          do_ss;
    logic          do_lap;

    // Single-winner pulse decode: the highest-ranked pulse masks the others.
    always_comb begin
        do_clr = CLEAR;
        do_ss  = START_STOP & ~CLEAR;
        do_lap = LAP & ~START_STOP & ~CLEAR;
    end

    // Next-state computation for the FSM, prescaler, cascade, lap capture and OVF.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cs_d      = cs_q;
        sec_d     = sec_q;
        min_d     = min_q;
        lap_cs_d  = lap_cs_q;
        lap_sec_d = lap_sec_q;
        lap_min_d = lap_min_q;
        ovf_d     = ovf_q;

        counting = (state_q == S_RUN) || (state_q == S_LAP);
        tick_now = counting && (pre_q == PRE_LAST);
        at_max   = (cs_q == 7'd99) && (sec_q == 6'd59) && (min_q == MIN_LAST);

        // Prescaler only advances while counting; in PAUSE the partial tick is kept.
        if (counting) begin
            pre_d = tick_now ? '0 : pre_q + PW'(1);
        end

        // Cascade advance; at the terminal value the count holds instead.
        if (tick_now && !at_max) begin
            if (cs_q == 7'd99) begin
                cs_d = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    min_d = min_q + 6'd1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                cs_d = cs_q + 7'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (do_ss) state_d = S_RUN;
            end
            S_RUN: begin
                if (do_ss) begin
                    state_d = S_PAUSE;
                end else if (do_lap) begin
                    // Capture the pre-tick live value on the LAP edge.
                    state_d   = S_LAP;
                    lap_cs_d  = cs_q;
                    lap_sec_d = sec_q;
                    lap_min_d = min_q;
                end
            end
            S_LAP: begin
                if (do_ss) begin
                    state_d = S_PAUSE;
                end else if (do_lap) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (do_clr) begin
                    state_d   = S_IDLE;
                    pre_d     = '0;
                    cs_d      = 7'd0;
                    sec_d     = 6'd0;
                    min_d     = 6'd0;
                    lap_cs_d  = 7'd0;
                    lap_sec_d = 6'd0;
                    lap_min_d = 6'd0;
                    ovf_d     = 1'b0;
                end else if (do_ss && !ovf_q) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Saturation overrides any pulse: freeze at the top and stop.
        if (tick_now && at_max) begin
            ovf_d   = 1'b1;
            state_d = S_PAUSE;
        end
    end

    // State registers and registered outputs; outputs track the next state so
    // a counter change shows up in the cycle right after its tick edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            cs_q      <= 7'd0;
            sec_q     <= 6'd0;
            min_q     <= 6'd0;
            lap_cs_q  <= 7'd0;
            lap_sec_q <= 6'd0;
            lap_min_q <= 6'd0;
            ovf_q     <= 1'b0;
            CS        <= 7'd0;
            SEC       <= 6'd0;
            MIN       <= 6'd0;
            RUNNING   <= 1'b0;
            LAP_HOLD  <= 1'b0;
            OVF       <= 1'b0;
            TICK      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cs_q      <= cs_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            lap_cs_q  <= lap_cs_d;
            lap_sec_q <= lap_sec_d;
            lap_min_q <= lap_min_d;
            ovf_q     <= ovf_d;
            if (state_d == S_LAP) begin
                CS  <= lap_cs_d;
                SEC <= lap_sec_d;
                MIN <= lap_min_d;
            end else begin
                CS  <= cs_d;
                SEC <= sec_d;
                MIN <= min_d;
            end
            RUNNING  <= (state_d == S_RUN) || (state_d == S_LAP);
            LAP_HOLD <= (state_d == S_LAP);
            OVF      <= ovf_d;
            TICK     <= tick_now;
        end
    end

endmodule

// File: tb/tb_ms_stopwatch_ctrl.sv
// tb_ms_stopwatch_ctrl: scoreboard bench for ms_stopwatch_ctrl. Two instances
// (TICK_DIV=4/MAX_MIN=59 and TICK_DIV=2/MAX_MIN=0) share clock and pulses; a
// reference model that tracks elapsed time as one centisecond total predicts
// every cycle's outputs of the selected instance, plus directed spot checks.
module tb_ms_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_stop = 1'b0;
    logic lap = 1'b0;
    logic clear = 1'b0;

    logic [6:0] a_cs, b_cs;
    logic [5:0] a_sec, b_sec, a_min, b_min;
    logic a_running, a_lap_hold, a_ovf, a_tick;
    logic b_running, b_lap_hold, b_ovf, b_tick;

    // clock / reset
    always #5 clk = ~clk;

    ms_stopwatch_ctrl #(.TICK_DIV(4), .MAX_MIN(59)) dut_a (
        .CLK(clk), .RST(rst), .START_STOP(start_stop), .LAP(lap), .CLEAR(clear),
        .CS(a_cs), .SEC(a_sec), .MIN(a_min), .RUNNING(a_running),
        .LAP_HOLD(a_lap_hold), .OVF(a_ovf), .TICK(a_tick)
    );

    ms_stopwatch_ctrl #(.TICK_DIV(2), .MAX_MIN(0)) dut_b (
        .CLK(clk), .RST(rst), .START_STOP(start_stop), .LAP(lap), .CLEAR(clear),
        .CS(b_cs), .SEC(b_sec), .MIN(b_min), .RUNNING(b_running),
        .LAP_HOLD(b_lap_hold), .OVF(b_ovf), .TICK(b_tick)
    );

    bit          sel_b = 1'b0;
    logic [22:0] got_vec;
    assign got_vec = sel_b ? {b_cs, b_sec, b_min, b_running, b_lap_hold, b_ovf, b_tick}
                           : {a_cs, a_sec, a_min, a_running, a_lap_hold, a_ovf, a_tick};

    // scoreboard state
    logic [22:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int n_fail_shown = 0;
    int tick_cnt = 0;

    // reference model: elapsed time as a single centisecond count
    typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE} mst_t;
    mst_t m_st;
    int   m_td = 4;
    int   m_max = 59;
    int   m_total, m_lap, m_pre;
    bit   m_ovf;

    function automatic logic [22:0] pack_out(int d, bit run, bit hold, bit ov, bit tk);
        logic [6:0] c;
        logic [5:0] s;
        logic [5:0] m;
        c = 7'(d % 100);
        s = 6'((d / 100) % 60);
        m = 6'(d / 6000);
        return {c, s, m, run, hold, ov, tk};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_total = 0; m_lap = 0; m_pre = 0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit ss, input bit lp, input bit cl, output logic [22:0] v);
        bit run, tk, sat;
        int old_total, disp;
        mst_t nst;
        bit p_cl, p_ss, p_lp;
        p_cl = cl; p_ss = ss && !cl; p_lp = lp && !ss && !cl;
        run = (m_st == M_RUN) || (m_st == M_LAP);
        tk  = run && (m_pre == m_td - 1);
        sat = tk && (m_total == (m_max + 1) * 6000 - 1);
        old_total = m_total;
        nst = m_st;
        if (run) m_pre = tk ? 0 : m_pre + 1;
        if (tk && !sat) m_total = m_total + 1;
        case (m_st)
            M_IDLE:  if (p_ss) nst = M_RUN;
            M_RUN:   if (p_ss) nst = M_PAUSE;
                     else if (p_lp) begin nst = M_LAP; m_lap = old_total; end
            M_LAP:   if (p_ss) nst = M_PAUSE; else if (p_lp) nst = M_RUN;
            M_PAUSE: if (p_cl) begin
                         nst = M_IDLE; m_total = 0; m_lap = 0; m_pre = 0; m_ovf = 1'b0;
                     end else if (p_ss && !m_ovf) nst = M_RUN;
            default: ;
        endcase
        if (sat) begin m_ovf = 1'b1; nst = M_PAUSE; end
        m_st = nst;
        disp = (m_st == M_LAP) ? m_lap : m_total;
        v = pack_out(disp, (m_st == M_RUN) || (m_st == M_LAP), m_st == M_LAP, m_ovf, tk);
    endtask

    // directed comparison against a bench-side constant
    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    endtask

    // monitor: pops one expected output vector per clock edge and compares
    always @(posedge clk) begin
        logic [22:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_vec === e) n_pass++;
            else if (n_fail_shown < 30) begin
                n_fail_shown++;
                $display("FAIL out t=%0t got cs=%0d sec=%0d min=%0d run=%b hold=%b ovf=%b tick=%b exp cs=%0d sec=%0d min=%0d run=%b hold=%b ovf=%b tick=%b",
                         $time, got_vec[22:16], got_vec[15:10], got_vec[9:4], got_vec[3], got_vec[2], got_vec[1], got_vec[0],
                         e[22:16], e[15:10], e[9:4], e[3], e[2], e[1], e[0]);
            end
        end
        if (got_vec[0] === 1'b1) tick_cnt++;
    end

    // driver: one clock edge per call; returns at the following negedge with pulses low
    task automatic step(input bit ss, input bit lp, input bit cl);
        logic [22:0] v;
        start_stop = ss; lap = lp; clear = cl;
        model_step(ss, lp, cl, v);
        exp_q.push_back(v);
        @(negedge clk);
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0);
    endtask

    // asynchronous reset mid-cycle; outputs must drop before any clock edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", int'(got_vec), 0);
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick_cnt = 0;
        check("rst_release_outputs", int'(got_vec), 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // reset, then 400 cycles of counting at TICK_DIV=4
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        tick_cnt = 0;
        idle(400);
        check("run400_ticks", tick_cnt, 100);
        check("run400_cs", int'(got_vec[22:16]), 0);
        check("run400_sec", int'(got_vec[15:10]), 1);
        check("run400_min", int'(got_vec[9:4]), 0);
        check("run400_running", int'(got_vec[3]), 1);

        // lap freeze at CS=20, release 40 cycles later
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(80);
        step(1'b0, 1'b1, 1'b0);
        tick_cnt = 0;
        idle(20);
        check("lap_frozen_cs", int'(got_vec[22:16]), 20);
        check("lap_frozen_hold", int'(got_vec[2]), 1);
        idle(20);
        check("lap_ticks_continue", tick_cnt, 10);
        step(1'b0, 1'b1, 1'b0);
        check("lap_release_cs", int'(got_vec[22:16]), 30);
        check("lap_release_hold", int'(got_vec[2]), 0);

        // pause mid tick period, resume, then stop and clear
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        tick_cnt = 0;
        idle(50);
        check("pause_no_tick", tick_cnt, 0);
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("clear_outputs", int'(got_vec), 0);
        step(1'b1, 1'b0, 1'b0);
        idle(8);
        check("restart_cs", int'(got_vec[22:16]), 2);

        // reset mid-run at CS=37
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(148);
        check("pre_rst_cs", int'(got_vec[22:16]), 37);
        do_reset();

        // randomized pulses
        rand_steps(3000);

        // simultaneous pulses
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 1'b1, 1'b0);
        check("ss_lap_hold", int'(got_vec[2]), 0);
        check("ss_lap_running", int'(got_vec[3]), 0);
        step(1'b1, 1'b0, 1'b1);
        check("clr_ss_running", int'(got_vec[3]), 0);
        check("clr_ss_cs", int'(got_vec[22:16]), 0);
        step(1'b0, 1'b1, 1'b0);
        check("idle_lap_ignored", int'(got_vec[3:2]), 0);

        // saturation with MAX_MIN=0, TICK_DIV=2
        sel_b = 1'b1;
        m_td = 2;
        m_max = 0;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(12000);
        check("sat_cs", int'(got_vec[22:16]), 99);
        check("sat_sec", int'(got_vec[15:10]), 59);
        check("sat_min", int'(got_vec[9:4]), 0);
        check("sat_ovf", int'(got_vec[1]), 1);
        check("sat_running", int'(got_vec[3]), 0);
        step(1'b1, 1'b0, 1'b0);
        check("sat_start_ignored", int'(got_vec[3]), 0);
        step(1'b0, 1'b0, 1'b1);
        check("sat_clear_outputs", int'(got_vec), 0);
        rand_steps(2000);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
